// File: rtl/qcs_dyn_pre_gen_cap_pkg.sv
// Shared types for the dynamic preamble generator output capture buffer.
//   cap_state_e : capture FSM states
//   cap_entry_t : one FIFO entry {sop, eop, I lanes, Q lanes} for the default lane geometry
package qcs_dyn_pre_gen_cap_pkg;

  localparam int unsigned CAP_DW  = 12;
  localparam int unsigned CAP_NCH = 2;
  localparam int unsigned CAP_LW  = CAP_DW * CAP_NCH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [CAP_LW-1:0] i;
    logic [CAP_LW-1:0] q;
  } cap_entry_t;

  // Width of a flattened entry for an arbitrary lane geometry.
  function automatic int unsigned cap_entry_width(int unsigned dw, int unsigned nch);
    return 2 + 2 * dw * nch;
  endfunction

endpackage

// File: rtl/qcs_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//   clk_i, rst_ni   : clock, async active-low reset
//   wr_en_i/data_i  : write request and data
//   wr_ready_o      : write accepted this cycle (not full, or a pop frees a slot)
//   rd_en_i         : pop head entry, ignored when empty
//   rd_data_o       : head entry (zero when empty)
//   rd_vld_o        : FIFO not empty
//   level_o         : occupancy
module qcs_sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_vld_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             empty, full, do_rd, do_wr;

  assign empty      = (level_q == '0);
  assign full       = (level_q == (AW+1)'(DEPTH));
  assign do_rd      = rd_en_i & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_ready_o = ~full | do_rd;
  assign do_wr      = wr_en_i & wr_ready_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      level_d = level_q + (AW+1)'(1);
    else if (do_rd && !do_wr) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_vld_o  = ~empty;
  assign level_o   = level_q;

endmodule

// File: rtl/qcs_dyn_pre_gen_out_capture.sv
// Multi-channel capture buffer for the dynamic preamble generator output.
// Beats (NCH I/Q pairs) seen while nhtp_re is high are staged one deep, framed into
// packets with SOP/EOP using an idle-gap timeout, and stored in a FWFT FIFO.
// The generator is never backpressured; beats that do not fit are dropped (ovf).
//   clk, reset_n           : clock, async active-low reset
//   cap_en, ovf_clr        : capture enable, overflow sticky clear pulse
//   nhtp_re, data_i/q      : generator valid strobe and lane-packed samples
//   rd_en, rd_vld, rd_*    : FIFO drain interface (head entry with sop/eop)
//   level, pkt_cnt         : FIFO occupancy, packets closed into the FIFO
//   ovf, busy              : beat-dropped sticky flag, FSM not idle
module qcs_dyn_pre_gen_out_capture
  import qcs_dyn_pre_gen_cap_pkg::*;
#(
  parameter int unsigned DW      = CAP_DW,
  parameter int unsigned NCH     = CAP_NCH,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cap_en,
  input  logic                     ovf_clr,
  input  logic                     nhtp_re,
  input  logic [NCH*DW-1:0]        data_i,
  input  logic [NCH*DW-1:0]        data_q,
  input  logic                     rd_en,
  output logic                     rd_vld,
  output logic [NCH*DW-1:0]        rd_data_i,
  output logic [NCH*DW-1:0]        rd_data_q,
  output logic                     rd_sop,
  output logic                     rd_eop,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              pkt_cnt,
  output logic                     ovf,
  output logic                     busy
);

  localparam int unsigned LW = NCH * DW;
  localparam int unsigned EW = cap_entry_width(DW, NCH);
  // Counter only needs to reach GAP_CYC-1; the GAP_CYC-th idle cycle closes the packet.
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYC - 1);

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [LW-1:0] i;
    logic [LW-1:0] q;
  } entry_t;

  cap_state_e  state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  entry_t      stg_q, stg_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        ovf_q, ovf_d;

  entry_t      beat, push_data, rd_entry;
  logic        push, wr_ready, pkt_inc, ovf_set;

  assign beat = '{sop: 1'b0, eop: 1'b0, i: data_i, q: data_q};

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    stg_d     = stg_q;
    push      = 1'b0;
    push_data = stg_q;
    pkt_inc   = 1'b0;
    ovf_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cap_en && nhtp_re) begin
          stg_d     = beat;
          stg_d.sop = 1'b1;
          gap_d     = '0;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!cap_en || (!nhtp_re && gap_q == GapLast)) begin
          // Close: flush the staged beat as the last of the packet.
          push          = 1'b1;
          push_data.eop = 1'b1;
          gap_d         = '0;
          if (wr_ready) begin
            pkt_inc = 1'b1;
            state_d = IDLE;
          end else begin
            ovf_set = 1'b1;
            state_d = DROP;
          end
        end else if (nhtp_re) begin
          push  = 1'b1;
          gap_d = '0;
          if (wr_ready) begin
            stg_d = beat;
          end else begin
            ovf_set = 1'b1;
            state_d = DROP;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DROP: begin
        if (!cap_en) begin
          state_d = IDLE;
        end else if (nhtp_re) begin
          gap_d = '0;
        end else if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_cnt_d = pkt_inc ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  // A new overflow takes priority over a coincident clear.
  assign ovf_d     = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      stg_q     <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      stg_q     <= stg_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  qcs_sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .wr_en_i    (push),
    .wr_data_i  (push_data),
    .wr_ready_o (wr_ready),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_entry),
    .rd_vld_o   (rd_vld),
    .level_o    (level)
  );

  assign rd_data_i = rd_entry.i;
  assign rd_data_q = rd_entry.q;
  assign rd_sop    = rd_entry.sop;
  assign rd_eop    = rd_entry.eop;
  assign pkt_cnt   = pkt_cnt_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
